road_sensor_encoder: RTL
========================

Name: road_sensor_encoder

Overview:
Upstream conditioning stage for the four-road traffic light controller. Per road, it counts vehicles from arrival/departure detector pulses and maps the occupancy count to the controller's 3-bit thermometer crowd code (000 EMPTY, 001 LESS, 011 MORE, 111 FULL). A hold filter debounces each code before it reaches the controller's S1..S4 inputs, so lights are not re-prioritised on transient glitches.

Parameters:
CNT_W, 6, width of each per-road occupancy counter
MAX_COUNT, 63, counter saturation value; must be <= 2^CNT_W-1
LESS_TH, 1, count >= LESS_TH gives LESS (001)
MORE_TH, 8, count >= MORE_TH gives MORE (011)
FULL_TH, 16, count >= FULL_TH gives FULL (111)
HOLD, 4, consecutive cycles a new level must persist before the output updates; legal range 1..255
Constraint: 0 < LESS_TH <= MORE_TH <= FULL_TH <= MAX_COUNT

Ports:
clock  input  1  single system clock; all state updates on posedge
clear  input  1  synchronous, active-high reset
arr    input  4  arrival pulse per road, bit i = road i+1, sampled each posedge
dep    input  4  departure pulse per road, sampled each posedge
S1     output 3  debounced crowd code, road 1
S2     output 3  debounced crowd code, road 2
S3     output 3  debounced crowd code, road 3
S4     output 3  debounced crowd code, road 4
level_chg output 4  one-cycle pulse; bit i high in the cycle after road i's S output updated
err    output 4  sticky per-road flag: underflow or overflow attempt

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous, active-high. Clear sampled high at a posedge sets, at that edge: all counts = 0, S1..S4 = 000, candidates = 000, hold counters = 0, level_chg = 0, err = 0. Clear has priority over arr/dep in the same cycle. Clear mid-debounce discards the pending candidate.
- Counter update per road at each posedge:
  - arr only: +1. At MAX_COUNT, hold and set err.
  - dep only: -1. At 0, hold and set err.
  - Both or neither: hold.
- Raw level is combinational from the registered count: FULL if >= FULL_TH, else MORE if >= MORE_TH, else LESS if >= LESS_TH, else EMPTY. Only the four legal codes are ever produced.
- Hold filter per road (registers cand[2:0], hc[7:0]), evaluated each posedge:
  - raw == S: cand <= S, hc <= 0.
  - raw != S and raw != cand: cand <= raw, hc <= 1. If HOLD == 1, also S <= raw.
  - raw != S and raw == cand: hc <= hc+1. When hc+1 == HOLD, S <= raw and hc <= 0.
  - Net latency: a count change registered at edge n updates S at edge n+HOLD, if raw is unchanged through that window.
  - A glitch back to S restarts the filter. A change to a third level restarts it with the new candidate.
  - Level skips are allowed (e.g. EMPTY -> MORE) with no intermediate step.
- level_chg[i] is registered: high for exactly one cycle after the edge at which road i's S changed.
- err[i] is sticky until clear.
- Roads are fully independent; simultaneous events on several roads are all processed in the same cycle.

Test Plan:
- Clear held 2 cycles with arr = 4'hF -> all S = 000, err = 0, level_chg = 0; counts stay 0.
- arr[0] pulse at edge n, no other activity -> S1 = 001 at edge n+4; level_chg[0] high one cycle; S2..S4 stay 000.
- arr[1] at n, dep[1] at n+2 -> S2 stays 000, level_chg[1] never pulses.
- arr[2] high for 16 consecutive edges starting at n -> S3 = 001 at n+4, 011 at n+11, 111 at n+19; three level_chg[2] pulses.
- dep[1] on an empty road -> count stays 0, err[1] = 1 and remains set. 64 arrivals on road 4 -> count 63, err[3] set on the 64th; S4 = 111.
- arr[0] and dep[0] simultaneous for 10 cycles from count 8 -> count stays 8, S1 unchanged. Then clear at edge m with arr[3] high -> all outputs 000 at m, arr ignored.

Source files
------------

// File: rtl/road_sensor_encoder.sv
// Per-road vehicle occupancy counter feeding a debounced 3-bit thermometer
// crowd code (EMPTY/LESS/MORE/FULL) for the four-road light controller.
module road_sensor_encoder #(
  parameter int CNT_W     = 6,
  parameter int MAX_COUNT = 63,
  parameter int LESS_TH   = 1,
  parameter int MORE_TH   = 8,
  parameter int FULL_TH   = 16,
  parameter int HOLD      = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] arr,
  input  logic [3:0] dep,
  output logic [2:0] S1,
  output logic [2:0] S2,
  output logic [2:0] S3,
  output logic [2:0] S4,
  output logic [3:0] level_chg,
  output logic [3:0] err
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] LESS_C = CNT_W'(LESS_TH);
  localparam logic [CNT_W-1:0] MORE_C = CNT_W'(MORE_TH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FULL_TH);
  localparam logic [7:0]       HOLD_C = 8'(HOLD);

  // Thermometer mapping of an occupancy count; only the four legal codes.
  function automatic logic [2:0] crowd_code(input logic [CNT_W-1:0] c);
    if (c >= FULL_C)      crowd_code = 3'b111;
    else if (c >= MORE_C) crowd_code = 3'b011;
    else if (c >= LESS_C) crowd_code = 3'b001;
    else                  crowd_code = 3'b000;
  endfunction

  logic [CNT_W-1:0] cnt_p0  [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [3:0]       err_hit;

  logic [2:0] raw     [4];
  logic [2:0] s_p1    [4];
  logic [2:0] cand_p1 [4];
  logic [7:0] hc_p1   [4];
  logic [2:0] s_nxt   [4];
  logic [2:0] cand_nxt[4];
  logic [7:0] hc_nxt  [4];
  logic [3:0] upd;

  // Saturating up/down count; a blocked step flags an error instead.
  always_comb begin
    err_hit = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt_p0[i];
      if (arr[i] && !dep[i]) begin
        if (cnt_p0[i] == MAX_C) err_hit[i] = 1'b1;
        else                    cnt_nxt[i] = cnt_p0[i] + CNT_W'(1);
      end else if (dep[i] && !arr[i]) begin
        if (cnt_p0[i] == '0) err_hit[i] = 1'b1;
        else                 cnt_nxt[i] = cnt_p0[i] - CNT_W'(1);
      end
    end
  end

  // Stage 0: occupancy counters and sticky error flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) cnt_p0[i] <= '0;
      err <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_p0[i] <= cnt_nxt[i];
      err <= err | err_hit;
    end
  end

  // Hold filter: a new level must persist HOLD evaluations before it is shown.
  always_comb begin
    upd = '0;
    for (int i = 0; i < 4; i++) begin
      raw[i]      = crowd_code(cnt_p0[i]);
      s_nxt[i]    = s_p1[i];
      cand_nxt[i] = cand_p1[i];
      hc_nxt[i]   = hc_p1[i];
      if (raw[i] == s_p1[i]) begin
        cand_nxt[i] = s_p1[i];
        hc_nxt[i]   = 8'd0;
      end else if (raw[i] != cand_p1[i]) begin
        cand_nxt[i] = raw[i];
        hc_nxt[i]   = 8'd1;
        if (HOLD_C == 8'd1) begin
          s_nxt[i] = raw[i];
          upd[i]   = 1'b1;
        end
      end else if (hc_p1[i] + 8'd1 == HOLD_C) begin
        s_nxt[i]  = raw[i];
        hc_nxt[i] = 8'd0;
        upd[i]    = 1'b1;
      end else begin
        hc_nxt[i] = hc_p1[i] + 8'd1;
      end
    end
  end

  // Stage 1: debounced codes, filter state and one-cycle change pulses.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        s_p1[i]    <= 3'b000;
        cand_p1[i] <= 3'b000;
        hc_p1[i]   <= 8'd0;
      end
      level_chg <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        s_p1[i]    <= s_nxt[i];
        cand_p1[i] <= cand_nxt[i];
        hc_p1[i]   <= hc_nxt[i];
      end
      level_chg <= upd;
    end
  end

  assign S1 = s_p1[0];
  assign S2 = s_p1[1];
  assign S3 = s_p1[2];
  assign S4 = s_p1[3];

endmodule
